// File: rtl/address_decoder_unit.sv
// address_decoder_unit
// Routes load/store accesses from the ASIP core to four data-side regions
// (data RAM, buttons, encrypted-image ROM, decrypted-image RAM). Offsets,
// strobes and write data are combinational. Read data is steered by a region
// captured one cycle earlier, matching the 1-cycle read latency of the memories.
module address_decoder_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [31:0] button_read,
    input  logic [31:0] ram_read,
    input  logic [31:0] encrypted_read,
    input  logic [31:0] data_input,
    output logic        ram_we,
    output logic        decrypted_we,
    output logic [31:0] ram_address,
    output logic [31:0] encrypted_address,
    output logic [31:0] decrypted_address,
    output logic [31:0] ram_data,
    output logic [31:0] decrypted_data,
    output logic [31:0] data_output,
    output logic        bad_access
);

    // Fixed memory map, inclusive bounds.
    localparam logic [31:0] RAM_HI = 32'h0000_03FF;
    localparam logic [31:0] BTN_LO = 32'h0000_0400;
    localparam logic [31:0] BTN_HI = 32'h0000_040F;
    localparam logic [31:0] ENC_LO = 32'h0000_4000;
    localparam logic [31:0] ENC_HI = 32'h0002_FFFF;
    localparam logic [31:0] DEC_LO = 32'h0003_0000;
    localparam logic [31:0] DEC_HI = 32'h0005_BFFF;

    // SEL_NONE doubles as "unmapped" and as the reset value of the read select.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_BTN,
        SEL_ENC,
        SEL_DEC
    } region_e;

    region_e region;
    region_e sel_d, sel_q;
    logic    bad_d, bad_q;

    // Decode the current address into its region.
    always_comb begin
        // NOTE: default assigned first so every path drives region; no latch is inferred.
        region = SEL_NONE;
        if (address <= RAM_HI) begin
            region = SEL_RAM;
        end else if (address >= BTN_LO && address <= BTN_HI) begin
            region = SEL_BTN;
        end else if (address >= ENC_LO && address <= ENC_HI) begin
            region = SEL_ENC;
        end else if (address >= DEC_LO && address <= DEC_HI) begin
            region = SEL_DEC;
        end
    end

    // Region-local offsets are always driven; subtraction wraps modulo 2^32.
    assign ram_address       = address;
    assign encrypted_address = address - ENC_LO;
    assign decrypted_address = address - DEC_LO;

    // Store data goes to both writable memories; only the strobe selects.
    assign ram_data       = data_input;
    assign decrypted_data = data_input;

    // Only RAM and DEC accept stores.
    assign ram_we       = write_enable && (region == SEL_RAM);
    assign decrypted_we = write_enable && (region == SEL_DEC);

    // Next state: remember the region for read steering; flag stores to read-only or unmapped space.
    always_comb begin
        sel_d = region;
        bad_d = write_enable && (region != SEL_RAM) && (region != SEL_DEC);
    end

    // Read-select and fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= SEL_NONE;
            bad_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for registered state keep every flop sampling pre-edge values.
            sel_q <= sel_d;
            bad_q <= bad_d;
        end
    end

    assign bad_access = bad_q;

    // Steer read data from the region captured in the previous cycle; DEC is write-only.
    always_comb begin
        data_output = '0;
        case (sel_q)
            SEL_RAM: data_output = ram_read;
            SEL_BTN: data_output = button_read;
            SEL_ENC: data_output = encrypted_read;
            default: data_output = '0;
        endcase
    end

endmodule

// File: tb/tb_address_decoder_unit.sv
// Self-checking bench for address_decoder_unit: a history-based reference model
// (previous address / write_enable) compared on every falling edge, plus
// directed literal expectations from the memory map.
module tb_address_decoder_unit;

    localparam int R_RAM = 0;
    localparam int R_BTN = 1;
    localparam int R_ENC = 2;
    localparam int R_DEC = 3;
    localparam int R_UNM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] button_read;
    logic [31:0] ram_read;
    logic [31:0] encrypted_read;
    logic [31:0] data_input;
    logic        ram_we;
    logic        decrypted_we;
    logic [31:0] ram_address;
    logic [31:0] encrypted_address;
    logic [31:0] decrypted_address;
    logic [31:0] ram_data;
    logic [31:0] decrypted_data;
    logic [31:0] data_output;
    logic        bad_access;

    int checks = 0;
    int errors = 0;

    address_decoder_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .write_enable      (write_enable),
        .address           (address),
        .button_read       (button_read),
        .ram_read          (ram_read),
        .encrypted_read    (encrypted_read),
        .data_input        (data_input),
        .ram_we            (ram_we),
        .decrypted_we      (decrypted_we),
        .ram_address       (ram_address),
        .encrypted_address (encrypted_address),
        .decrypted_address (decrypted_address),
        .ram_data          (ram_data),
        .decrypted_data    (decrypted_data),
        .data_output       (data_output),
        .bad_access        (bad_access)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Region of a byte address, straight from the memory map.
    function automatic int region_of(input logic [31:0] a);
        if (a < 32'h400)                          return R_RAM;
        if (a < 32'h410)                          return R_BTN;
        if (a >= 32'h4000  && a < 32'h30000)      return R_ENC;
        if (a >= 32'h30000 && a < 32'h5C000)      return R_DEC;
        return R_UNM;
    endfunction

    // Reference history: the access presented in the last clocked cycle.
    logic        hist_valid = 1'b0;
    logic [31:0] hist_addr  = '0;
    logic        hist_we    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid <= 1'b0;
        end else begin
            hist_valid <= 1'b1;
            hist_addr  <= address;
            hist_we    <= write_enable;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int          cur;
        int          prv;
        logic [31:0] exp_dout;
        logic        exp_bad;
        cur = region_of(address);
        prv = hist_valid ? region_of(hist_addr) : R_UNM;
        exp_dout = 32'h0;
        if (prv == R_RAM) exp_dout = ram_read;
        if (prv == R_BTN) exp_dout = button_read;
        if (prv == R_ENC) exp_dout = encrypted_read;
        exp_bad = hist_valid && hist_we && (prv == R_BTN || prv == R_ENC || prv == R_UNM);
        check("m_ram_we",       {31'b0, ram_we},       {31'b0, write_enable && cur == R_RAM});
        check("m_decrypted_we", {31'b0, decrypted_we}, {31'b0, write_enable && cur == R_DEC});
        check("m_ram_address",  ram_address,           address);
        check("m_enc_address",  encrypted_address,     address - 32'd16384);
        check("m_dec_address",  decrypted_address,     address - 32'd196608);
        check("m_ram_data",     ram_data,              data_input);
        check("m_dec_data",     decrypted_data,        data_input);
        check("m_data_output",  data_output,           exp_dout);
        check("m_bad_access",   {31'b0, bad_access},   {31'b0, exp_bad});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bnd [12] = '{32'h3FC, 32'h3FF, 32'h400, 32'h40F, 32'h410, 32'h3FFF,
                              32'h4000, 32'h2FFFF, 32'h30000, 32'h5BFFF, 32'h5C000, 32'hFFFF_FFFF};

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return bnd[$urandom_range(0, 11)];
            1:       return 32'($urandom_range(0, 32'h3FF));
            2:       return 32'h400 + 32'($urandom_range(0, 15));
            3:       return 32'($urandom_range(32'h4000, 32'h2FFFF));
            4:       return 32'($urandom_range(32'h30000, 32'h5BFFF));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n          = 1'b0;
        write_enable   = 1'b0;
        address        = 32'h4;
        button_read    = '0;
        ram_read       = 32'h999;
        encrypted_read = '0;
        data_input     = '0;

        // Reset behaviour and first RAM read.
        #3;
        check("rst_ram_address", ram_address, 32'h4);
        check("rst_ram_we", {31'b0, ram_we}, 32'h0);
        check("rst_data_output", data_output, 32'h0);
        check("rst_bad_access", {31'b0, bad_access}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_first", data_output, 32'h0);
        @(negedge clk);
        check("ram_read_0x4", data_output, 32'h999);

        // Button reads and faulted store.
        tick(); address = 32'h404; button_read = 32'h666;
        @(negedge clk);
        tick();
        @(negedge clk); check("btn_read", data_output, 32'h666);
        tick(); write_enable = 1'b1;
        @(negedge clk); check("btn_wr_ram_we", {31'b0, ram_we}, 32'h0);
        check("btn_wr_dec_we", {31'b0, decrypted_we}, 32'h0);
        tick(); write_enable = 1'b0; address = 32'h40C;
        @(negedge clk); check("btn_bad_pulse", {31'b0, bad_access}, 32'h1);
        tick(); write_enable = 1'b1;
        @(negedge clk); check("btn_bad_one_cycle", {31'b0, bad_access}, 32'h0);
        check("btn_40c_read", data_output, 32'h666);
        tick(); write_enable = 1'b0; address = 32'h400;
        @(negedge clk); check("btn_40c_bad", {31'b0, bad_access}, 32'h1);
        tick(); address = 32'h410;
        @(negedge clk); check("btn_400_read", data_output, 32'h666);

        // Decrypted RAM store and write-only read.
        tick(); address = 32'h30000; data_input = 32'hF; write_enable = 1'b1;
        @(negedge clk); check("unmapped_410_read", data_output, 32'h0);
        check("dec_we", {31'b0, decrypted_we}, 32'h1);
        check("dec_address", decrypted_address, 32'h0);
        check("dec_data", decrypted_data, 32'hF);
        check("dec_ram_we", {31'b0, ram_we}, 32'h0);
        tick(); write_enable = 1'b0;
        @(negedge clk); check("dec_no_bad", {31'b0, bad_access}, 32'h0);
        check("dec_read_zero", data_output, 32'h0);

        // Encrypted ROM read and faulted store.
        tick(); address = 32'h4100; encrypted_read = 32'h24A;
        @(negedge clk); check("enc_address", encrypted_address, 32'h100);
        tick(); write_enable = 1'b1;
        @(negedge clk); check("enc_read", data_output, 32'h24A);
        check("enc_wr_ram_we", {31'b0, ram_we}, 32'h0);
        check("enc_wr_dec_we", {31'b0, decrypted_we}, 32'h0);

        // Boundaries.
        tick(); write_enable = 1'b0; address = 32'h3FC; ram_read = 32'h123;
        @(negedge clk); check("enc_bad_pulse", {31'b0, bad_access}, 32'h1);
        tick(); address = 32'h3FFF;
        @(negedge clk); check("bnd_3fc_ram", data_output, 32'h123);
        tick(); address = 32'h2FFFC;
        @(negedge clk); check("bnd_3fff_unm", data_output, 32'h0);
        tick(); address = 32'h5BFFC;
        @(negedge clk); check("bnd_2fffc_enc", data_output, 32'h24A);
        tick(); address = 32'h5C000; write_enable = 1'b1;
        @(negedge clk); check("bnd_5bffc_dec", data_output, 32'h0);
        check("bnd_5c000_no_we", {31'b0, decrypted_we}, 32'h0);
        tick(); address = 32'h5BFFC; write_enable = 1'b0;
        @(negedge clk); check("bnd_5c000_bad", {31'b0, bad_access}, 32'h1);
        check("bnd_5c000_read", data_output, 32'h0);

        // Asynchronous reset mid-access.
        tick(); address = 32'h0; ram_read = 32'h777;
        tick(); address = 32'h4;
        @(negedge clk); check("pre_async_rst", data_output, 32'h777);
        #1 rst_n = 1'b0;
        #1 check("async_rst_dout", data_output, 32'h0);
        check("async_rst_ram_addr", ram_address, 32'h4);
        tick(); rst_n = 1'b1;
        @(negedge clk); check("post_async_first", data_output, 32'h0);
        @(negedge clk); check("post_async_read", data_output, 32'h777);

        // Randomized traffic checked by the model on every falling edge.
        for (int i = 0; i < 400; i++) begin
            tick();
            address        = rand_addr();
            write_enable   = 1'($urandom_range(0, 1));
            button_read    = $urandom;
            ram_read       = $urandom;
            encrypted_read = $urandom;
            data_input     = $urandom;
            if (i == 200) begin
                @(negedge clk);
                #1 rst_n = 1'b0;
                #1 check("rand_async_rst", data_output, 32'h0);
                tick();
                rst_n = 1'b1;
            end
        end
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
